// File: rtl/cnu_min_finder.sv
// Serial check-node min-sum core: reduces one row of sign-magnitude V2C messages
// to {min1, min2, min1 index, sign product}. Offset-min-sum enabled by CNU_OFFSET_EN.
module cnu_min_finder #(
    parameter int nob     = 4,
    parameter int MAX_DEG = 19,
    parameter int IDX_W   = 5,
    parameter int OFFSET  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [nob:0]     in_msg,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [nob-1:0]   out_min1,
    output logic [nob-1:0]   out_min2,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_sign,
    output logic             out_err
);

    localparam logic [nob-1:0] MAG_MAX = {nob{1'b1}};
    localparam logic [IDX_W-1:0] LAST_POS = IDX_W'(MAX_DEG - 1);

`ifdef CNU_OFFSET_EN
    localparam bit OFF_ON = 1'b1;
`else
    localparam bit OFF_ON = 1'b0;
`endif
    localparam int OFF_AMT = OFF_ON ? OFFSET : 0;

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t           state;
    logic [nob-1:0]   min1;
    logic [nob-1:0]   min2;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] pos;
    logic             sgn;

    logic             s;
    logic [nob-1:0]   m;
    logic             accept;
    logic             row_end;
    logic [nob-1:0]   n_min1;
    logic [nob-1:0]   n_min2;
    logic [IDX_W-1:0] n_idx;
    logic             n_sgn;

    // Handshake: a message moves on in_valid && in_ready, a result on
    // out_valid && out_ready; in_ready never looks at in_valid.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // The -2^nob pattern (negative zero) saturates to the largest magnitude.
    assign s = in_msg[nob];
    assign m = (s && (in_msg[nob-1:0] == '0)) ? MAG_MAX : in_msg[nob-1:0];

    assign row_end = accept && (in_last || (pos == LAST_POS));

    function automatic logic [nob-1:0] off_min(input logic [nob-1:0] v);
        if (int'(v) > OFF_AMT) return v - nob'(OFF_AMT);
        else return '0;
    endfunction

    always_comb begin
        n_min1 = min1;
        n_min2 = min2;
        n_idx  = idx;
        n_sgn  = sgn ^ s;
        if (state == IDLE) begin
            n_min1 = m;
            n_min2 = MAG_MAX;
            n_idx  = '0;
            n_sgn  = s;
        end else if (m < min1) begin
            n_min2 = min1;
            n_min1 = m;
            n_idx  = pos;
        end else if (m < min2) begin
            n_min2 = m;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            min1      <= '0;
            min2      <= '0;
            idx       <= '0;
            pos       <= '0;
            sgn       <= 1'b0;
            out_valid <= 1'b0;
            out_min1  <= '0;
            out_min2  <= '0;
            out_idx   <= '0;
            out_sign  <= 1'b0;
            out_err   <= 1'b0;
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            if (accept) begin
                if (row_end) begin
                    out_min1  <= off_min(n_min1);
                    out_min2  <= off_min(n_min2);
                    out_idx   <= n_idx;
                    out_sign  <= n_sgn;
                    out_err   <= !in_last;
                    out_valid <= 1'b1;
                    state     <= IDLE;
                    pos       <= '0;
                end else begin
                    min1  <= n_min1;
                    min2  <= n_min2;
                    idx   <= n_idx;
                    sgn   <= n_sgn;
                    pos   <= pos + 1'b1;
                    state <= ACCUM;
                end
            end
        end
    end

endmodule

// File: tb/tb_cnu_min_finder.sv
// Bench for cnu_min_finder: table vectors, directed corner sequences and random rows
// checked against a whole-row reference model through an expected-result queue.
module tb_cnu_min_finder;

    localparam int NOB     = 4;
    localparam int MAX_DEG = 19;
    localparam int IDX_W   = 5;
    localparam int OFFSET  = 1;
    localparam int W       = 2 * NOB + IDX_W + 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [NOB:0]     in_msg;
    logic             in_last;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [NOB-1:0]   out_min1;
    logic [NOB-1:0]   out_min2;
    logic [IDX_W-1:0] out_idx;
    logic             out_sign;
    logic             out_err;
    logic [W-1:0]     actual;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];
    logic [NOB:0] row_q[$];
    bit use_model  = 1'b1;
    bit rand_ready = 1'b0;
    bit mon_en     = 1'b0;

    cnu_min_finder #(.nob(NOB), .MAX_DEG(MAX_DEG), .IDX_W(IDX_W), .OFFSET(OFFSET)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_msg(in_msg), .in_last(in_last),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_min1(out_min1), .out_min2(out_min2), .out_idx(out_idx),
        .out_sign(out_sign), .out_err(out_err)
    );

    assign actual = {out_min1, out_min2, out_idx, out_sign, out_err};

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [NOB-1:0] offm(input logic [NOB-1:0] v);
`ifdef CNU_OFFSET_EN
        return (int'(v) > OFFSET) ? v - 4'(OFFSET) : 4'd0;
`else
        return v;
`endif
    endfunction

    function automatic logic [W-1:0] mk(input int mn1, input int mn2, input int ix,
                                        input bit sg, input bit er);
        return {offm(4'(mn1)), offm(4'(mn2)), 5'(ix), sg, er};
    endfunction

    // Whole-row reference: decode every message, then pick minima over the array.
    function automatic logic [W-1:0] ref_row(input logic [NOB:0] msgs[$], input bit err);
        int mags[$];
        int best = 0;
        int second = 15;
        bit sg = 1'b0;
        foreach (msgs[i]) begin
            mags.push_back((msgs[i][4] && msgs[i][3:0] == 4'd0) ? 15 : int'(msgs[i][3:0]));
            sg ^= msgs[i][4];
        end
        foreach (mags[i]) if (mags[i] < mags[best]) best = i;
        foreach (mags[i]) if (i != best && mags[i] < second) second = mags[i];
        return mk(mags[best], second, best, sg, err);
    endfunction

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic record_accept(input logic [NOB:0] msg, input bit last);
        row_q.push_back(msg);
        if (last || row_q.size() == MAX_DEG) begin
            if (use_model) exp_q.push_back(ref_row(row_q, !last));
            row_q.delete();
        end
    endtask

    // driver tasks (start and end at posedge + 1)
    task automatic send_msg(input logic [NOB:0] msg, input bit last, output int waits);
        in_valid = 1'b1;
        in_msg   = msg;
        in_last  = last;
        waits    = 0;
        @(negedge clk);
        while (!in_ready && waits < 200) begin
            waits++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: got in_ready=0 want 1");
        end else begin
            record_accept(msg, last);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 300 && exp_q.size() > 0; k++) @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // scoreboard: every visible result must match the queue head, also while stalled
    always @(negedge clk) begin
        if (mon_en && !rst && out_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got %h want none", actual);
            end else begin
                check("result", actual, exp_q[0]);
                if (!out_ready) check("stall_in_ready", W'(in_ready), W'(0));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    typedef struct {
        int           len;
        logic [NOB:0] msg [8];
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs[6];
    int   waits;

    initial begin
        vecs[0] = '{4, '{5'h05, 5'h13, 5'h02, 5'h07, 5'h00, 5'h00, 5'h00, 5'h00}, mk(2, 3, 2, 1, 0)};
        vecs[1] = '{3, '{5'h04, 5'h04, 5'h10, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00}, mk(4, 4, 0, 1, 0)};
        vecs[2] = '{1, '{5'h1F, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00}, mk(15, 15, 0, 1, 0)};
        vecs[3] = '{3, '{5'h0F, 5'h01, 5'h01, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00}, mk(1, 1, 1, 0, 0)};
        vecs[4] = '{3, '{5'h1F, 5'h10, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00}, mk(0, 15, 2, 0, 0)};
        vecs[5] = '{7, '{5'h07, 5'h03, 5'h09, 5'h02, 5'h0A, 5'h02, 5'h1E, 5'h00}, mk(2, 2, 3, 1, 0)};

        // reset state
        rst = 1'b1; in_valid = 1'b0; in_msg = '0; in_last = 1'b0; out_ready = 1'b1;
        idle(2);
        check("reset_out_valid", W'(out_valid), W'(0));
        check("reset_outputs", actual, W'(0));
        check("reset_in_ready", W'(in_ready), W'(1));
        rst = 1'b0;
        mon_en = 1'b1;
        idle(1);

        // table vectors with 1-cycle latency check
        use_model = 1'b0;
        for (int v = 0; v < 6; v++) begin
            exp_q.push_back(vecs[v].exp);
            for (int i = 0; i < vecs[v].len; i++) send_msg(vecs[v].msg[i], i == vecs[v].len - 1, waits);
            check("latency", W'(out_valid), W'(1));
            wait_drain();
        end
        use_model = 1'b1;

        // reset mid-row discards the partial row; next row restarts at position 0
        send_msg(5'h03, 1'b0, waits);
        send_msg(5'h12, 1'b0, waits);
        rst = 1'b1;
        #1;
        check("midrow_rst_valid", W'(out_valid), W'(0));
        check("midrow_rst_outputs", actual, W'(0));
        row_q.delete();
        exp_q.delete();
        idle(1);
        rst = 1'b0;
        idle(1);
        send_msg(5'h05, 1'b0, waits);
        send_msg(5'h13, 1'b0, waits);
        send_msg(5'h02, 1'b0, waits);
        send_msg(5'h07, 1'b1, waits);
        wait_drain();

        // backpressure: held result, in_ready low, same-cycle accept on release
        out_ready = 1'b0;
        send_msg(5'h05, 1'b0, waits);
        send_msg(5'h13, 1'b0, waits);
        send_msg(5'h02, 1'b0, waits);
        send_msg(5'h07, 1'b1, waits);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("stall_valid", W'(out_valid), W'(1));
            check("stall_ready", W'(in_ready), W'(0));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send_msg(5'h0A, 1'b0, waits);
        check("release_same_cycle_accept", W'(waits), W'(0));
        send_msg(5'h01, 1'b1, waits);
        wait_drain();

        // truncation at MAX_DEG, then the 20th message forms its own row
        for (int i = 0; i < 20; i++) send_msg(5'h09, i == 19, waits);
        wait_drain();

        // random rows, random gaps and random output backpressure
        rand_ready = 1'b1;
        for (int r = 0; r < 60; r++) begin
            int len;
            len = $urandom_range(1, 22);
            for (int i = 0; i < len; i++) begin
                bit last;
                last = (i == len - 1) && ((r == 59) || ($urandom_range(0, 3) != 0));
                send_msg(5'($urandom_range(0, 31)), last, waits);
                if ($urandom_range(0, 4) == 0) idle(1);
            end
        end
        wait_drain();
        rand_ready = 1'b0;
        out_ready = 1'b1;
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
